// File: rtl/dmem_pkg.sv
// Shared types and sizes for the data-memory arbiter.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  localparam int unsigned DMEM_DEPTH = 64;
  localparam int unsigned WORD_W     = 32;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker; last_gnt remembers the most recently granted port.
module rr_arb2 (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt_onehot
);

  logic last_gnt_q, last_gnt_d;

  always_comb begin
    gnt_onehot = 2'b00;
    unique case (req)
      2'b01:   gnt_onehot = 2'b01;
      2'b10:   gnt_onehot = 2'b10;
      // Contention: favour the port that was not served last.
      2'b11:   gnt_onehot = last_gnt_q ? 2'b01 : 2'b10;
      default: gnt_onehot = 2'b00;
    endcase
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (advance && (gnt_onehot != 2'b00)) begin
      last_gnt_d = gnt_onehot[1];
    end
  end

  // Reset to 1 so port 0 wins the first contention.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      last_gnt_q <= 1'b1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin sequencer in front of the single-ported data memory.
// Every output is registered; one access takes an ACCESS cycle and a RESP cycle.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DMEM_DEPTH,
  parameter int unsigned DW    = WORD_W,
  parameter int unsigned AW    = 32
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          ack0,
  output logic          err0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          ack1,
  output logic          err1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data_in,
  output logic          mem_MemRead,
  output logic          mem_MemWrite,
  input  logic [DW-1:0] mem_data_out
);

  localparam logic [AW-1:0] DepthA = AW'(DEPTH);

  state_e        state_q, state_d;
  logic          port_q, port_d;
  logic          we_q, we_d;
  logic          oor_q, oor_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    ack_q, ack_d;
  logic [1:0]    err_q, err_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic [AW-1:0] maddr_q, maddr_d;
  logic [DW-1:0] mdin_q, mdin_d;
  logic          mrd_q, mrd_d;
  logic          mwr_q, mwr_d;

  logic [1:0]    pick;
  logic          advance;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_oor;

  rr_arb2 u_rr_arb2 (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .req        ({req1, req0}),
    .advance    (advance),
    .gnt_onehot (pick)
  );

  assign sel_we    = pick[1] ? we1    : we0;
  assign sel_addr  = pick[1] ? addr1  : addr0;
  assign sel_wdata = pick[1] ? wdata1 : wdata0;
  assign sel_oor   = (sel_addr >= DepthA);

  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    we_d     = we_q;
    oor_d    = oor_q;
    maddr_d  = maddr_q;
    mdin_d   = mdin_q;
    gnt_d    = 2'b00;
    ack_d    = 2'b00;
    err_d    = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    mrd_d    = 1'b0;
    mwr_d    = 1'b0;
    advance  = 1'b0;

    unique case (state_q)
      IDLE, RESP: begin
        if (pick != 2'b00) begin
          advance = 1'b1;
          state_d = ACCESS;
          port_d  = pick[1];
          we_d    = sel_we;
          oor_d   = sel_oor;
          // Address/data only move on a grant so the memory never sees stray changes.
          maddr_d = sel_addr;
          mdin_d  = sel_wdata;
          gnt_d   = pick;
          mwr_d   = sel_we & ~sel_oor;
          mrd_d   = ~sel_we & ~sel_oor;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d        = RESP;
        ack_d[port_q]  = 1'b1;
        err_d[port_q]  = oor_q;
        if (!we_q) begin
          if (port_q) begin
            rdata1_d = oor_q ? '0 : mem_data_out;
          end else begin
            rdata0_d = oor_q ? '0 : mem_data_out;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      oor_q    <= 1'b0;
      gnt_q    <= 2'b00;
      ack_q    <= 2'b00;
      err_q    <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
      maddr_q  <= '0;
      mdin_q   <= '0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      we_q     <= we_d;
      oor_q    <= oor_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      maddr_q  <= maddr_d;
      mdin_q   <= mdin_d;
      mrd_q    <= mrd_d;
      mwr_q    <= mwr_d;
    end
  end

  assign gnt0         = gnt_q[0];
  assign gnt1         = gnt_q[1];
  assign ack0         = ack_q[0];
  assign ack1         = ack_q[1];
  assign err0         = err_q[0];
  assign err1         = err_q[1];
  assign rdata0       = rdata0_q;
  assign rdata1       = rdata1_q;
  assign mem_address  = maddr_q;
  assign mem_data_in  = mdin_q;
  assign mem_MemRead  = mrd_q;
  assign mem_MemWrite = mwr_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected grants and responses are queued as
// requests are issued and popped by a negedge monitor.
module tb_dmem_arbiter;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, ack0, err0, gnt1, ack1, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_MemRead, mem_MemWrite;

  always #5 Clk = ~Clk;

  dmem_arbiter #(
    .DEPTH (64),
    .DW    (32),
    .AW    (32)
  ) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .req0         (req0),
    .we0          (we0),
    .addr0        (addr0),
    .wdata0       (wdata0),
    .gnt0         (gnt0),
    .ack0         (ack0),
    .err0         (err0),
    .rdata0       (rdata0),
    .req1         (req1),
    .we1          (we1),
    .addr1        (addr1),
    .wdata1       (wdata1),
    .gnt1         (gnt1),
    .ack1         (ack1),
    .err1         (err1),
    .rdata1       (rdata1),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_MemRead  (mem_MemRead),
    .mem_MemWrite (mem_MemWrite),
    .mem_data_out (mem_data_out)
  );

  // Memory model: combinational read, write at the clock edge ending the strobe.
  logic [31:0] mem [64];
  logic        mem_init;
  assign mem_data_out = mem[mem_address[5:0]];

  always @(posedge Clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (mem_MemWrite) begin
      mem[mem_address[5:0]] <= mem_data_in;
    end
  end

  typedef struct {
    int          port;
    logic        rd;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  resp_t       exp_resp[$];
  int          exp_gnt[$];
  logic [31:0] ref_mem [64];
  logic [31:0] exp_last [2];
  int          n_total = 0;
  int          n_bad = 0;
  int          wr_cycles = 0;
  int          rd_cycles = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_access(input int p, input logic w, input logic [31:0] a,
                               input logic [31:0] d);
    resp_t r;
    logic  oor;
    oor     = (a >= 32'd64);
    r.port  = p;
    r.rd    = ~w;
    r.err   = oor;
    r.rdata = 32'h0;
    if (w && !oor) ref_mem[a[5:0]] = d;
    if (!w && !oor) r.rdata = ref_mem[a[5:0]];
    exp_gnt.push_back(p);
    exp_resp.push_back(r);
  endtask

  task automatic mon_gnt(input int p);
    int e;
    if (exp_gnt.size() == 0) begin
      check($sformatf("gnt%0d_unexpected", p), 64'(1), 64'(0));
    end else begin
      e = exp_gnt.pop_front();
      check("gnt_order", 64'(p), 64'(e));
    end
  endtask

  task automatic mon_ack(input int p, input logic err, input logic [31:0] rdata);
    resp_t r;
    if (exp_resp.size() == 0) begin
      check($sformatf("ack%0d_unexpected", p), 64'(1), 64'(0));
    end else begin
      r = exp_resp.pop_front();
      check("ack_port", 64'(p), 64'(r.port));
      check($sformatf("err%0d", p), 64'(err), 64'(r.err));
      if (r.rd) begin
        check($sformatf("rdata%0d_read", p), 64'(rdata), 64'(r.rdata));
        exp_last[p] = r.rdata;
      end else begin
        check($sformatf("rdata%0d_hold", p), 64'(rdata), 64'(exp_last[p]));
      end
    end
  endtask

  always @(negedge Clk) begin
    if (!Rst_n) begin
      exp_last[0] = 32'h0;
      exp_last[1] = 32'h0;
    end else begin
      if (mem_MemRead && mem_MemWrite) check("strobe_excl", 64'(1), 64'(0));
      if (mem_MemWrite) wr_cycles++;
      if (mem_MemRead) rd_cycles++;
      if (gnt0) mon_gnt(0);
      if (gnt1) mon_gnt(1);
      if (ack0) mon_ack(0, err0, rdata0);
      if (ack1) mon_ack(1, err1, rdata1);
    end
  end

  // Call just after a negedge; returns at the negedge where gnt is seen, req dropped.
  task automatic do_req(input int p, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    if (p == 0) begin
      req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge Clk);
      lat++;
      got = (p == 0) ? gnt0 : gnt1;
    end
    if (!got) check($sformatf("gnt_timeout_p%0d", p), 64'(0), 64'(1));
    if (p == 0) req0 = 1'b0;
    else req1 = 1'b0;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && (exp_resp.size() != 0 || exp_gnt.size() != 0); i++) begin
      @(negedge Clk);
    end
    check("drain_resp", 64'(exp_resp.size()), 64'(0));
    check("drain_gnt", 64'(exp_gnt.size()), 64'(0));
    @(negedge Clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat0, lat1, w0, r0, nd;
    logic acc;
    Rst_n = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    mem_init = 1'b1;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
    @(negedge Clk);
    mem_init = 1'b0;
    check("rst_ctl", 64'({gnt0, gnt1, ack0, ack1, err0, err1, mem_MemRead, mem_MemWrite}),
          64'(0));
    check("rst_rdata", 64'({rdata0, rdata1}), 64'(0));
    check("rst_mem_if", 64'({mem_address, mem_data_in}), 64'(0));
    do_reset();

    // Port 0 write then read of address 5.
    w0 = wr_cycles;
    expect_access(0, 1'b1, 32'd5, 32'hDEAD_BEEF);
    do_req(0, 1'b1, 32'd5, 32'hDEAD_BEEF, lat);
    check("t1_wr_gnt_lat", 64'(lat), 64'(1));
    @(negedge Clk);
    check("t1_wr_ack", 64'(ack0), 64'(1));
    expect_access(0, 1'b0, 32'd5, 32'h0);
    do_req(0, 1'b0, 32'd5, 32'h0, lat);
    check("t1_rd_gnt_lat", 64'(lat), 64'(1));
    @(negedge Clk);
    check("t1_rd_ack", 64'(ack0), 64'(1));
    check("t1_rd_data", 64'(rdata0), 64'(32'hDEAD_BEEF));
    drain();
    check("t1_wr_pulse", 64'(wr_cycles - w0), 64'(1));

    // Simultaneous requests out of reset: port 0 first, port 1 right after ack0.
    do_reset();
    expect_access(0, 1'b0, 32'd1, 32'h0);
    expect_access(1, 1'b0, 32'd2, 32'h0);
    fork
      do_req(0, 1'b0, 32'd1, 32'h0, lat0);
      do_req(1, 1'b0, 32'd2, 32'h0, lat1);
    join
    check("t2_gnt0_lat", 64'(lat0), 64'(1));
    check("t2_gnt1_lat", 64'(lat1), 64'(3));
    drain();

    // Continuous contention: strict alternation 0,1,0,1,...
    do_reset();
    for (int k = 0; k < 4; k++) begin
      expect_access(0, 1'b1, 32'(10 + k), 32'h1000_0000 + 32'(k));
      expect_access(1, 1'b0, 32'(10 + k), 32'h0);
    end
    fork
      begin
        for (int k = 0; k < 4; k++) do_req(0, 1'b1, 32'(10 + k), 32'h1000_0000 + 32'(k), lat0);
      end
      begin
        for (int k = 0; k < 4; k++) do_req(1, 1'b0, 32'(10 + k), 32'h0, lat1);
      end
    join
    drain();

    // Out-of-range read and write on port 1.
    w0 = wr_cycles;
    r0 = rd_cycles;
    expect_access(1, 1'b0, 32'd64, 32'h0);
    do_req(1, 1'b0, 32'd64, 32'h0, lat);
    check("t4_gnt_lat", 64'(lat), 64'(1));
    @(negedge Clk);
    check("t4_ack", 64'({ack1, err1}), 64'(2'b11));
    check("t4_rdata", 64'(rdata1), 64'(0));
    expect_access(1, 1'b1, 32'd100, 32'hCAFE_F00D);
    do_req(1, 1'b1, 32'd100, 32'hCAFE_F00D, lat);
    drain();
    check("t4_no_wr", 64'(wr_cycles - w0), 64'(0));
    check("t4_no_rd", 64'(rd_cycles - r0), 64'(0));
    nd = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) nd++;
    check("t4_mem_intact", 64'(nd), 64'(0));

    // Reset during ACCESS of a port 0 read: no ack must follow.
    exp_gnt.push_back(0);
    do_req(0, 1'b0, 32'd3, 32'h0, lat);
    #2 Rst_n = 1'b0;
    #1;
    check("t5_rst_ctl",
          64'({gnt0, gnt1, ack0, ack1, err0, err1, mem_MemRead, mem_MemWrite}), 64'(0));
    check("t5_rst_data", 64'({rdata0, rdata1}), 64'(0));
    check("t5_rst_mem_if", 64'({mem_address, mem_data_in}), 64'(0));
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      acc = acc | ack0;
    end
    check("t5_no_ack0", 64'(acc), 64'(0));
    expect_access(1, 1'b0, 32'd7, 32'h0);
    do_req(1, 1'b0, 32'd7, 32'h0, lat);
    check("t5_gnt1_lat", 64'(lat), 64'(1));
    @(negedge Clk);
    check("t5_ack1", 64'(ack1), 64'(1));
    drain();

    // Boundary address 63: port 1 writes, port 0 reads back.
    expect_access(1, 1'b1, 32'd63, 32'h1234_5678);
    do_req(1, 1'b1, 32'd63, 32'h1234_5678, lat);
    expect_access(0, 1'b0, 32'd63, 32'h0);
    do_req(0, 1'b0, 32'd63, 32'h0, lat);
    drain();
    check("t6_rdata0", 64'(rdata0), 64'(32'h1234_5678));
    check("t6_err0", 64'(err0), 64'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
